// File: rtl/usart_pkg.sv
// Shared definitions for the 8N1 serial blocks: FSM states and line-format constants.
package usart_pkg;

  localparam int USART_DATA_BITS     = 8;
  localparam int USART_MIN_PRESCALER = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } usart_state_e;

endpackage

// File: rtl/usart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level (1).
module usart_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/usart_rx.sv
// 8N1 serial receiver: start validation at mid-bit, LSB-first data capture,
// level-valid/ack holding register with overrun and framing-error reporting.
module usart_rx
  import usart_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic               rx_pin,
  input  logic               rx_ack,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               overrun,
  output logic               frame_error,
  output logic               rx_busy
);

  logic rx_s;

  usart_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx_pin),
    .q     (rx_s)
  );

  usart_state_e       state_reg, state_next;
  logic [PRESC_W-1:0] cnt_reg, cnt_next;
  logic [PRESC_W-1:0] p_reg, p_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic [7:0]         shift_reg, shift_next;
  logic               armed_reg, armed_next;
  logic               load;
  logic               fe_next;
  logic [7:0]         rx_data_next;
  logic               rx_valid_next, overrun_next;
  logic [PRESC_W-1:0] half_m1, full_m1;

  // cnt is 0 on the START entry edge, so the mid-start sample lands h edges later at cnt == h-1.
  assign half_m1 = (p_reg >> 1) - PRESC_W'(1);
  assign full_m1 = p_reg - PRESC_W'(1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + PRESC_W'(1);
    p_next       = p_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    armed_next   = armed_reg | rx_s;
    load         = 1'b0;
    fe_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (armed_reg && !rx_s && (prescaler >= PRESC_W'(USART_MIN_PRESCALER))) begin
          state_next = START;
          p_next     = prescaler;
        end
      end
      START: begin
        if (cnt_reg == half_m1) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == full_m1) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s;
          bit_idx_next            = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'(USART_DATA_BITS - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_reg == full_m1) begin
          cnt_next = '0;
          if (rx_s) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            // Disarm so a line stuck low cannot start a fresh frame until it goes high.
            fe_next    = 1'b1;
            armed_next = 1'b0;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    rx_data_next  = rx_data;
    rx_valid_next = rx_valid;
    overrun_next  = overrun;
    if (load) begin
      // A load always wins over a coincident ack; the ack only suppresses the overrun.
      rx_data_next  = shift_reg;
      rx_valid_next = 1'b1;
      overrun_next  = rx_valid & ~rx_ack;
    end else if (rx_ack && rx_valid) begin
      rx_valid_next = 1'b0;
      overrun_next  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      p_reg       <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      armed_reg   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      p_reg       <= p_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      armed_reg   <= armed_next;
      rx_data     <= rx_data_next;
      rx_valid    <= rx_valid_next;
      overrun     <= overrun_next;
      frame_error <= fe_next;
    end
  end

  assign rx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: good frames, glitch, framing error, overrun, ack collision,
// illegal prescaler and mid-frame reset, with a byte scoreboard.
module tb_usart_rx;

  localparam int PRESC_W = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [PRESC_W-1:0] prescaler = 16'd16;
  logic               rx_pin = 1'b1;
  logic               rx_ack = 1'b0;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               overrun;
  logic               frame_error;
  logic               rx_busy;

  int   vectors     = 0;
  int   miscompares = 0;
  int   fe_count    = 0;
  bit   fe_with_valid = 1'b0;
  logic [7:0] exp_q[$];

  usart_rx #(.PRESC_W(PRESC_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .prescaler   (prescaler),
    .rx_pin      (rx_pin),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .overrun     (overrun),
    .frame_error (frame_error),
    .rx_busy     (rx_busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_error) begin
      fe_count++;
      if (rx_valid) fe_with_valid = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] frame(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // Cycle index n drives the level sampled at edge k+n; returns #1 after edge k+to-1.
  task automatic drive(input logic [9:0] bits, input int p, input int from, input int to);
    for (int n = from; n < to; n++) begin
      rx_pin = bits[n / p];
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input int p);
    prescaler = PRESC_W'(p);
    exp_q.push_back(d);
    drive(frame(d, 1'b1), p, 0, 10 * p);
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clock);
    #1;
    rx_ack = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %0h expected none", tag, rx_data);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(rx_data), 32'(e));
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_data", 32'(rx_data), 0);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_fe", 32'(frame_error), 0);
    check("rst_busy", 32'(rx_busy), 0);
    reset = 1'b1;
    idle(5);

    // Good frame with exact load timing at edge k+154
    prescaler = 16'd16;
    exp_q.push_back(8'hA5);
    drive(frame(8'hA5, 1'b1), 16, 0, 154);
    check("t1_valid_early", 32'(rx_valid), 0);
    check("t1_busy_mid", 32'(rx_busy), 1);
    drive(frame(8'hA5, 1'b1), 16, 154, 155);
    check("t1_valid", 32'(rx_valid), 1);
    pop_check("t1_data");
    check("t1_busy_done", 32'(rx_busy), 0);
    drive(frame(8'hA5, 1'b1), 16, 155, 160);
    idle(5);
    check("t1_fe", 32'(fe_count), 0);
    check("t1_overrun", 32'(overrun), 0);
    ack_pulse();
    check("t1_ack_valid", 32'(rx_valid), 0);

    // Glitch: four low cycles
    drive(10'h000, 16, 0, 4);
    check("t2_busy_start", 32'(rx_busy), 1);
    idle(20);
    check("t2_busy_end", 32'(rx_busy), 0);
    check("t2_valid", 32'(rx_valid), 0);
    check("t2_fe", 32'(fe_count), 0);

    // Framing error then good frame
    drive(frame(8'h3C, 1'b0), 16, 0, 160);
    idle(10);
    check("t3_fe_count", 32'(fe_count), 1);
    check("t3_fe_valid", 32'(fe_with_valid), 0);
    check("t3_valid", 32'(rx_valid), 0);
    check("t3_busy", 32'(rx_busy), 0);
    send(8'h81, 16);
    idle(3);
    check("t3_valid2", 32'(rx_valid), 1);
    pop_check("t3_data");
    ack_pulse();

    // Overrun
    send(8'h11, 8);
    idle(2);
    pop_check("t4_data1");
    check("t4_ovr1", 32'(overrun), 0);
    send(8'h22, 8);
    idle(2);
    pop_check("t4_data2");
    check("t4_ovr2", 32'(overrun), 1);
    ack_pulse();
    check("t4_ack_valid", 32'(rx_valid), 0);
    check("t4_ack_ovr", 32'(overrun), 0);

    // Ack on the exact load edge of 0x55, with overrun pending
    send(8'h33, 8);
    idle(2);
    pop_check("t5_data1");
    send(8'h44, 8);
    idle(2);
    pop_check("t5_data2");
    check("t5_ovr_pre", 32'(overrun), 1);
    prescaler = 16'd8;
    exp_q.push_back(8'h55);
    drive(frame(8'h55, 1'b1), 8, 0, 78);
    rx_ack = 1'b1;
    drive(frame(8'h55, 1'b1), 8, 78, 79);
    rx_ack = 1'b0;
    pop_check("t5_data3");
    check("t5_valid", 32'(rx_valid), 1);
    check("t5_ovr", 32'(overrun), 0);
    drive(frame(8'h55, 1'b1), 8, 79, 80);
    idle(2);

    // Illegal prescaler: nothing starts
    prescaler = 16'd3;
    drive(10'h000, 3, 0, 12);
    check("t6_busy", 32'(rx_busy), 0);
    idle(3);
    check("t6_valid", 32'(rx_valid), 1);
    check("t6_data", 32'(rx_data), 32'h55);

    // Reset during data bit 3 of 0xF0
    prescaler = 16'd8;
    drive(frame(8'hF0, 1'b1), 8, 0, 36);
    reset = 1'b0;
    #1;
    check("t7_data", 32'(rx_data), 0);
    check("t7_valid", 32'(rx_valid), 0);
    check("t7_ovr", 32'(overrun), 0);
    check("t7_fe", 32'(frame_error), 0);
    check("t7_busy", 32'(rx_busy), 0);
    rx_pin = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(5);
    check("t7_busy_rel", 32'(rx_busy), 0);
    send(8'h0F, 8);
    idle(3);
    pop_check("t7_data2");
    check("t7_valid2", 32'(rx_valid), 1);
    check("t7_ovr2", 32'(overrun), 0);
    check("t7_fe_total", 32'(fe_count), 1);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
